// File: rtl/line_clear.sv
// line_clear: removes full rows from an 8x16 playfield, one row examined per cycle,
// and accumulates the number of cleared rows into a saturating 3-digit BCD score.
module line_clear #(
    parameter int unsigned SCORE_MAX = 999
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] map_in,
    output logic [127:0] map_out,
    output logic         busy,
    output logic         done,
    output logic [4:0]   lines,
    output logic [11:0]  score
);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    localparam logic [11:0] MAX_BCD = {4'(SCORE_MAX / 100),
                                       4'((SCORE_MAX / 10) % 10),
                                       4'(SCORE_MAX % 10)};

    state_t        state_q;
    logic [127:0]  w_q;
    logic [3:0]    y_q;
    logic [4:0]    cnt_q;
    logic [127:0]  map_q;
    logic [4:0]    lines_q;
    logic [11:0]   score_q;
    logic          busy_q;
    logic          done_q;

    logic          row_full;
    logic [127:0]  w_shift_d;
    logic [11:0]   score_d;

    logic [3:0]    c_t;
    logic [3:0]    c_o;
    logic [4:0]    s_o;
    logic [4:0]    s_t;
    logic [4:0]    s_h;
    logic          co_o;
    logic          co_t;
    logic [11:0]   sum_bcd;

    assign row_full = (w_q[8*y_q +: 8] == 8'hFF);

    // Drop every row above the current one down by one; the top row refills empty.
    always_comb begin
        w_shift_d = w_q;
        w_shift_d[7:0] = 8'h00;
        for (int r = 1; r < 16; r++) begin
            if (r <= int'(y_q)) begin
                w_shift_d[8*r +: 8] = w_q[8*(r-1) +: 8];
            end
        end
    end

    // BCD add of the cleared-row count into the score, clamped at SCORE_MAX.
    always_comb begin
        c_t  = (cnt_q >= 5'd10) ? 4'd1 : 4'd0;
        c_o  = (cnt_q >= 5'd10) ? 4'(cnt_q - 5'd10) : cnt_q[3:0];
        co_o = 1'b0;
        co_t = 1'b0;
        s_o  = 5'(score_q[3:0]) + 5'(c_o);
        if (s_o > 5'd9) begin
            s_o  = s_o - 5'd10;
            co_o = 1'b1;
        end
        s_t = 5'(score_q[7:4]) + 5'(c_t) + 5'(co_o);
        if (s_t > 5'd9) begin
            s_t  = s_t - 5'd10;
            co_t = 1'b1;
        end
        s_h     = 5'(score_q[11:8]) + 5'(co_t);
        sum_bcd = {s_h[3:0], s_t[3:0], s_o[3:0]};
        if ((s_h > 5'd9) || (sum_bcd > MAX_BCD)) begin
            score_d = MAX_BCD;
        end else begin
            score_d = sum_bcd;
        end
    end

    // Control FSM; results and done are registered on the last scan edge so
    // they are already final during the single FINISH cycle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            y_q     <= 4'd15;
            cnt_q   <= '0;
            map_q   <= '0;
            lines_q <= '0;
            score_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        w_q     <= map_in;
                        y_q     <= 4'd15;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        w_q   <= w_shift_d;
                        cnt_q <= cnt_q + 5'd1;
                    end else if (y_q != 4'd0) begin
                        y_q <= y_q - 4'd1;
                    end else begin
                        map_q   <= w_q;
                        lines_q <= cnt_q;
                        score_q <= score_d;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign map_out = map_q;
    assign lines   = lines_q;
    assign score   = score_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear: directed checks of row removal, latency, BCD score,
// saturation, ignored starts and asynchronous abort for line_clear.
module tb_line_clear;

    logic         CLK = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] map_in;
    logic [127:0] map_out;
    logic         busy;
    logic         done;
    logic [4:0]   lines;
    logic [11:0]  score;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

    logic [127:0] m1, e1, m4, e4, mg, eg, m2, m8, full;

    line_clear #(.SCORE_MAX(999)) dut (
        .CLK(CLK),
        .reset(reset),
        .start(start),
        .map_in(map_in),
        .map_out(map_out),
        .busy(busy),
        .done(done),
        .lines(lines),
        .score(score)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] bcd(input int v);
        bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [127:0] m,
                          input int n, input logic [127:0] exp_map,
                          input bit poke);
        int lat;
        map_in = m;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start  = 1'b0;
        map_in = ~m;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        lat = 0;
        while (lat < 100) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (done === 1'b1) break;
        end
        exp_sc = (exp_sc + n > 999) ? 999 : exp_sc + n;
        chk({tag, "_lat"}, 128'(lat), 128'(16 + n));
        chk({tag, "_lines"}, 128'(lines), 128'(n));
        chk({tag, "_map"}, map_out, exp_map);
        chk({tag, "_score"}, 128'(score), 128'(bcd(exp_sc)));
        chk({tag, "_busyfin"}, 128'(busy), 128'(1));
        if (poke) begin
            map_in = '1;
            start  = 1'b1;
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(negedge CLK);
        chk({tag, "_donelo"}, 128'(done), 128'(0));
        chk({tag, "_idle"}, 128'(busy), 128'(0));
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, "_idle2"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int dcnt;
        m1   = {8'hFF, 8'h01, 112'h0};
        e1   = {8'h01, 120'h0};
        m4   = {32'hFFFF_FFFF, 8'h3C, 88'h0};
        e4   = {8'h3C, 120'h0};
        m2   = {16'hFFFF, 112'h0};
        m8   = {{8{8'hFF}}, 64'h0};
        full = '1;
        mg   = '0;
        mg[127:120] = 8'hFF;
        mg[119:112] = 8'h81;
        mg[111:104] = 8'hFF;
        mg[103:96]  = 8'h18;
        mg[7:0]     = 8'hAA;
        eg   = '0;
        eg[127:120] = 8'h81;
        eg[119:112] = 8'h18;
        eg[23:16]   = 8'hAA;

        reset  = 1'b0;
        start  = 1'b0;
        map_in = '0;
        repeat (3) @(negedge CLK);
        chk("rst_map", map_out, 128'h0);
        chk("rst_lines", 128'(lines), 128'(0));
        chk("rst_score", 128'(score), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));

        reset = 1'b1;
        run_op("one_row", m1, 1, e1, 1'b0);
        chk("sc_001", 128'(score), 128'(12'h001));
        run_op("four_rows", m4, 4, e4, 1'b0);
        chk("sc_005", 128'(score), 128'(12'h005));
        run_op("gaps", mg, 2, eg, 1'b0);
        run_op("empty", 128'h0, 0, 128'h0, 1'b0);
        run_op("two_rows", m2, 2, 128'h0, 1'b0);
        chk("sc_009", 128'(score), 128'(12'h009));
        run_op("carry", m1, 1, e1, 1'b1);
        chk("sc_010", 128'(score), 128'(12'h010));

        map_in = m4;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("hold_map", map_out, e1);
        chk("hold_lines", 128'(lines), 128'(1));
        map_in = full;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start  = 1'b0;
        map_in = '0;
        exp_sc = exp_sc + 4;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (done === 1'b1) begin
                dcnt++;
                chk("ign_lines", 128'(lines), 128'(4));
                chk("ign_map", map_out, e4);
                chk("ign_score", 128'(score), 128'(12'h014));
            end
        end
        chk("ign_dones", 128'(dcnt), 128'(1));
        chk("ign_busy", 128'(busy), 128'(0));

        for (int i = 0; i < 61; i++) begin
            run_op("full", full, 16, 128'h0, 1'b0);
        end
        chk("sc_990", 128'(score), 128'(12'h990));
        run_op("eight", m8, 8, 128'h0, 1'b0);
        chk("sc_998", 128'(score), 128'(12'h998));
        run_op("sat", m4, 4, e4, 1'b0);
        chk("sc_sat", 128'(score), 128'(12'h999));
        run_op("sat2", m1, 1, e1, 1'b0);
        chk("sc_sat2", 128'(score), 128'(12'h999));

        map_in = m4;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("ab_busy", 128'(busy), 128'(0));
        chk("ab_done", 128'(done), 128'(0));
        chk("ab_map", map_out, 128'h0);
        chk("ab_lines", 128'(lines), 128'(0));
        chk("ab_score", 128'(score), 128'(0));
        dcnt = 0;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
            if (done === 1'b1) dcnt++;
        end
        chk("ab_nodone", 128'(dcnt), 128'(0));
        exp_sc = 0;
        reset = 1'b1;
        run_op("after_rst", m1, 1, e1, 1'b0);
        chk("sc_after", 128'(score), 128'(12'h001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
